turn_signal_sequencer: RTL
==========================

Name: turn_signal_sequencer

Overview:
Parametrised successor to the lab tail-light FSM. Drives a symmetric bar of 2*LEDS_PER_SIDE lamps with sequential left/right turn animations and a hazard flash mode. Step timing comes from an internal prescaler rather than raw clock edges. Sits under the board top level, with buttons as inputs and board LEDs as outputs.

Parameters:
LEDS_PER_SIDE, 3, lamps per side; must be >= 1.
STEP_CYCLES, 4, clock cycles per animation step; must be >= 1. Counter width is max(1, $clog2(STEP_CYCLES)).

Ports:
clk  input  1  system clock, rising-edge active.
reset  input  1  asynchronous, active-low reset.
left  input  1  left-turn request, level, sampled on rising clk.
right  input  1  right-turn request, level, sampled on rising clk.
hazard  input  1  hazard request, level, sampled on rising clk.
leds  output  2*LEDS_PER_SIDE  lamp drive, registered.
- leds[2N-1:N] is the left half; leds[N] is the innermost left lamp.
- leds[N-1:0] is the right half; leds[N-1] is the innermost right lamp.
busy  output  1  registered; high whenever state != IDLE.

Behaviour:
- Reset: when reset is low, immediately (asynchronously) force state=IDLE, step=0, prescaler=0, leds=0, busy=0. This applies mid-sequence as well. On release, the first active edge evaluates requests.
- States: IDLE, LEFT, RIGHT, HAZ_ON, HAZ_OFF.
- Prescaler: counts 0..STEP_CYCLES-1 while not in IDLE. A "tick" is when the count equals STEP_CYCLES-1. The count clears on every state entry.
- IDLE exits. Priority: hazard > (left & right) > left > right.
  - hazard, or left and right together -> HAZ_ON.
  - left -> LEFT with step=1.
  - right -> RIGHT with step=1.
  - Outputs are registered, so the first lamp pattern appears on the same edge that leaves IDLE: one clock of latency from the sampling edge.
- LEFT step k (1..N): the k innermost left lamps are lit, i.e. leds[N+k-1:N]=1 and all else 0.
  - Step N+1: all lamps off.
  - Each step lasts exactly STEP_CYCLES clocks, so a full sequence is (N+1)*STEP_CYCLES clocks.
- RIGHT: mirror image of LEFT. Step k lights leds[N-1:N-k].
- End of LEFT/RIGHT (tick at step N+1):
  - If hazard is high -> HAZ_ON.
  - Else if the same direction request is still high -> restart at step 1 with no idle gap.
  - Else if the opposite direction request is high -> start that direction at step 1.
  - Else -> IDLE.
- Mid-sequence requests:
  - left/right are ignored with no queuing; a pulse that ends before the sequence end is lost.
  - hazard preempts on the next edge -> HAZ_ON, prescaler cleared.
- HAZ_ON: all 2N lamps on. On tick -> HAZ_OFF.
- HAZ_OFF: all lamps off. On tick:
  - If hazard, or left and right together, is still high -> HAZ_ON.
  - Else -> IDLE.
  - Hazard drop therefore always completes the current on+off pair.
  - The next request is evaluated from IDLE on the following edge.
- STEP_CYCLES=1: every clock is a tick, so a pattern changes every clock.
- Inputs are assumed already synchronised and debounced. Requests narrower than one clock period may be missed; the bench must hold requests across at least one rising edge.

Test Plan:
(N=3, STEP_CYCLES=4 unless stated.)
1. Reset low for 5 clocks, then release with no requests -> leds=6'b000000, busy=0 for 20 clocks.
2. left high for 1 clock from IDLE -> leds 001000, 011000, 111000, 000000, 4 clocks each. busy high for exactly 16 clocks, then IDLE.
3. right held high for 40 clocks -> 000100, 000110, 000111, 000000 repeating with no gap. After release, the current sequence completes, then leds=0 and busy=0.
4. Hazard:
   - hazard held for 10 clocks -> 111111 for 4 clocks, 000000 for 4, 111111 for 4, 000000 for 4, then IDLE.
   - left & right asserted together for 1 clock -> one on/off pair only.
5. Preemption and ignoring:
   - left pulse, then hazard at step 2 -> next edge leds=111111 and the flash starts.
   - left pulse, then right pulse during step 3 -> right is ignored and the bar returns to IDLE.
6. Reset and parameter sweep:
   - reset low asynchronously mid-step (between edges) during LEFT step 2 -> leds=0 and busy=0 before the next edge.
   - Repeat test 2 with N=5, STEP_CYCLES=1 -> six patterns, one per clock: 0000100000, 0001100000, 0011100000, 0111100000, 1111100000, 0000000000.

Source files
------------

// File: rtl/turn_signal_sequencer_if.sv
// Request/lamp bundle between the board top level and the turn-signal sequencer.
// master drives the button levels; slave returns the registered lamp bar and busy.
interface turn_signal_sequencer_if #(
  parameter int LEDS_PER_SIDE = 3
);
  logic                         left;
  logic                         right;
  logic                         hazard;
  logic [2*LEDS_PER_SIDE-1:0]   leds;
  logic                         busy;

  modport master (
    output left,
    output right,
    output hazard,
    input  leds,
    input  busy
  );

  modport slave (
    input  left,
    input  right,
    input  hazard,
    output leds,
    output busy
  );
endinterface

// File: rtl/turn_signal_sequencer.sv
// Sequential left/right turn animation and hazard flash for a 2*N lamp bar, stepped by a prescaler.
// Outputs registered, first pattern one clock after the sampling edge; level inputs, no backpressure.
module turn_signal_sequencer #(
  parameter int LEDS_PER_SIDE = 3,
  parameter int STEP_CYCLES   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  turn_signal_sequencer_if.slave bus
);
  localparam int N  = LEDS_PER_SIDE;
  localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int SW = $clog2(N + 2);
  localparam logic [PW-1:0] PMAX = PW'(STEP_CYCLES - 1);
  localparam logic [SW-1:0] LAST = SW'(N + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEFT    = 3'd1,
    RIGHT   = 3'd2,
    HAZ_ON  = 3'd3,
    HAZ_OFF = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   step, step_nxt;
  logic [PW-1:0]   presc, presc_nxt;
  logic [2*N-1:0]  leds_q, leds_nxt;
  logic            busy_q, busy_nxt;
  logic            tick;
  logic            both;

  assign tick = (state != IDLE) && (presc == PMAX);
  assign both = bus.left & bus.right;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      step   <= '0;
      presc  <= '0;
      leds_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      step   <= step_nxt;
      presc  <= presc_nxt;
      leds_q <= leds_nxt;
      busy_q <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    case (state)
      IDLE: begin
        if (bus.hazard || both) begin
          state_nxt = HAZ_ON;
          step_nxt  = '0;
        end else if (bus.left) begin
          state_nxt = LEFT;
          step_nxt  = SW'(1);
        end else if (bus.right) begin
          state_nxt = RIGHT;
          step_nxt  = SW'(1);
        end
      end
      LEFT, RIGHT: begin
        if (bus.hazard) begin
          state_nxt = HAZ_ON;
          step_nxt  = '0;
        end else if (tick) begin
          if (step != LAST) begin
            step_nxt = step + 1'b1;
          end else if ((state == LEFT) ? bus.left : bus.right) begin
            // same direction still requested: loop with no idle gap
            step_nxt = SW'(1);
          end else if ((state == LEFT) ? bus.right : bus.left) begin
            state_nxt = (state == LEFT) ? RIGHT : LEFT;
            step_nxt  = SW'(1);
          end else begin
            state_nxt = IDLE;
            step_nxt  = '0;
          end
        end
      end
      HAZ_ON: begin
        if (tick) state_nxt = HAZ_OFF;
      end
      HAZ_OFF: begin
        if (tick) state_nxt = (bus.hazard || both) ? HAZ_ON : IDLE;
      end
      default: begin
        state_nxt = IDLE;
        step_nxt  = '0;
      end
    endcase

    // restart the step timer on any state entry, including the very first
    if ((state_nxt != state) || tick || (state == IDLE)) begin
      presc_nxt = '0;
    end else begin
      presc_nxt = presc + 1'b1;
    end
  end

  always_comb begin
    leds_nxt = '0;
    busy_nxt = (state_nxt != IDLE);
    case (state_nxt)
      HAZ_ON: leds_nxt = '1;
      LEFT: begin
        for (int i = 0; i < N; i++) begin
          leds_nxt[N+i] = (step_nxt != LAST) && (i < int'(step_nxt));
        end
      end
      RIGHT: begin
        for (int i = 0; i < N; i++) begin
          leds_nxt[N-1-i] = (step_nxt != LAST) && (i < int'(step_nxt));
        end
      end
      default: leds_nxt = '0;
    endcase
  end

  assign bus.leds = leds_q;
  assign bus.busy = busy_q;
endmodule
